// File: rtl/ddram_bram_responder.sv
// Qword-addressed BRAM that answers a burst read/write memory port over a fixed address window.
// It also has a single-cycle backdoor port, so the contents can be preloaded and inspected directly.
module ddram_bram_responder #(
    parameter int unsigned ADDR_BITS  = 12,
    parameter logic [28:0] BASE_QADDR = 29'h06080000,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [28:0]          rd_addr,
    input  logic [7:0]           rd_burstcnt,
    input  logic                 rd_req,
    output logic                 rd_ack,
    output logic [63:0]          rd_data,
    output logic                 rd_data_valid,
    input  logic [28:0]          wr_addr,
    input  logic [7:0]           wr_burstcnt,
    input  logic [63:0]          wr_data,
    input  logic [7:0]           wr_be,
    input  logic                 wr_req,
    output logic                 wr_ack,
    output logic                 wr_busy,
    input  logic                 bd_we,
    input  logic [ADDR_BITS-1:0] bd_addr,
    input  logic [63:0]          bd_wdata,
    output logic [63:0]          bd_rdata,
    output logic                 err_oob
);

    // state     | meaning
    // IDLE      | no transaction; arbitrates rd_req over wr_req
    // RD_WAIT   | read accepted, counting down the initial latency
    // RD_STREAM | emitting read beats; leaves the cycle after the last beat
    // WR_BURST  | first write beat taken, waiting for the remaining beats
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_STREAM, WR_BURST} state_t;

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    state_t state, state_next;

    logic [63:0] mem [DEPTH];

    logic [28:0]          rd_cur;
    logic [8:0]           rd_left;
    logic [2:0]           wait_cnt;
    logic [28:0]          wr_cur;
    logic [8:0]           wr_left;
    logic                 quiet;
    logic                 wr_ack_final;

    logic                 idle_open;
    logic                 accept_rd;
    logic                 accept_wr;
    logic                 issue_rd;
    logic                 wr_final;
    logic [28:0]          wr_beat_addr;

    logic [8:0]           rd_total_in;
    logic [8:0]           wr_total_in;
    logic [28:0]          rd_off;
    logic [28:0]          wr_off;
    logic                 rd_beat_in;
    logic                 wr_beat_in;
    logic [ADDR_BITS-1:0] rd_idx;
    logic [ADDR_BITS-1:0] wr_idx;

    assign rd_total_in = (rd_burstcnt == 8'd0) ? 9'd1 : {1'b0, rd_burstcnt};
    assign wr_total_in = (wr_burstcnt == 8'd0) ? 9'd1 : {1'b0, wr_burstcnt};

    // Offset compare instead of BASE + DEPTH, so the window end never overflows 29 bits.
    assign rd_off     = rd_cur - BASE_QADDR;
    assign wr_off     = wr_beat_addr - BASE_QADDR;
    assign rd_beat_in = (rd_cur >= BASE_QADDR) && ((rd_off >> ADDR_BITS) == 29'd0);
    assign wr_beat_in = (wr_beat_addr >= BASE_QADDR) && ((wr_off >> ADDR_BITS) == 29'd0);
    assign rd_idx     = rd_off[ADDR_BITS-1:0];
    assign wr_idx     = wr_off[ADDR_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_rd)                  state_next = RD_WAIT;
                else if (accept_wr && !wr_final) state_next = WR_BURST;
            end
            RD_WAIT:   if (wait_cnt == 3'd0)        state_next = RD_STREAM;
            RD_STREAM: if (rd_left == 9'd0)         state_next = IDLE;
            WR_BURST:  if (accept_wr && wr_final)   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // While rd_ack/wr_ack is up, and for one cycle after a final ack, the requestor may still be
    // holding the request it was just granted, so IDLE must not re-grant it.
    always_comb begin
        idle_open    = 1'b0;
        accept_rd    = 1'b0;
        accept_wr    = 1'b0;
        issue_rd     = 1'b0;
        wr_final     = 1'b0;
        wr_beat_addr = wr_cur;
        if (!reset) begin
            idle_open = !quiet && !rd_ack && !wr_ack;
            case (state)
                IDLE: begin
                    wr_beat_addr = wr_addr;
                    wr_final     = (wr_total_in == 9'd1);
                    accept_rd    = idle_open && rd_req;
                    accept_wr    = idle_open && !rd_req && wr_req;
                end
                RD_WAIT:   issue_rd = (wait_cnt == 3'd0);
                RD_STREAM: issue_rd = (rd_left != 9'd0);
                WR_BURST: begin
                    wr_final  = (wr_left == 9'd1);
                    accept_wr = wr_req && !wr_ack;
                end
                default: ;
            endcase
        end
    end

    // Later non-blocking writes win, so a protocol beat overrides a same-index backdoor write.
    always_ff @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_wdata;
        if (accept_wr && wr_beat_in) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_be[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ack        <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_data       <= 64'd0;
            wr_ack        <= 1'b0;
            wr_ack_final  <= 1'b0;
            wr_busy       <= 1'b0;
            err_oob       <= 1'b0;
            bd_rdata      <= 64'd0;
            quiet         <= 1'b0;
            rd_cur        <= 29'd0;
            rd_left       <= 9'd0;
            wait_cnt      <= 3'd0;
            wr_cur        <= 29'd0;
            wr_left       <= 9'd0;
        end else begin
            rd_ack        <= accept_rd;
            rd_data_valid <= issue_rd;
            wr_ack        <= accept_wr;
            wr_ack_final  <= accept_wr && wr_final;
            quiet         <= rd_ack || wr_ack_final;
            wr_busy       <= (state == WR_BURST);
            err_oob       <= (issue_rd && !rd_beat_in) || (accept_wr && !wr_beat_in);
            bd_rdata      <= mem[bd_addr];

            if (accept_rd) begin
                rd_cur   <= rd_addr;
                rd_left  <= rd_total_in;
                wait_cnt <= 3'(RD_LATENCY - 1);
            end else if (state == RD_WAIT && wait_cnt != 3'd0) begin
                wait_cnt <= wait_cnt - 3'd1;
            end

            if (issue_rd) begin
                rd_data <= rd_beat_in ? mem[rd_idx] : 64'd0;
                rd_cur  <= rd_cur + 29'd1;
                rd_left <= rd_left - 9'd1;
            end

            if (accept_wr) begin
                wr_cur  <= wr_beat_addr + 29'd1;
                wr_left <= (state == IDLE) ? wr_total_in - 9'd1 : wr_left - 9'd1;
            end
        end
    end

endmodule

// File: doc/ddram_bram_responder.md
DDRAM_BRAM_RESPONDER -- requirements
Module: ddram_bram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, log2 of qword depth of internal RAM.
REQ-002 SHALL have parameter BASE_QADDR, default 29'h06080000, first qword address served.
REQ-003 SHALL have parameter RD_LATENCY, default 2, cycles from rd_ack to first rd_data_valid (legal 1..8).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 rd_addr  in  29  qword read start address; rd_burstcnt  in  8  beats; rd_req  in  1  read request, held until rd_ack.
REQ-007 rd_ack  out  1  one-cycle read accept; rd_data  out  64  beat data; rd_data_valid  out  1  beat strobe.
REQ-008 wr_addr  in  29  qword address of first beat; wr_burstcnt  in  8  beats; wr_data  in  64; wr_be  in  8  byte enables; wr_req  in  1  beat offered, held until wr_ack.
REQ-009 wr_ack  out  1  one-cycle per-beat accept; wr_busy  out  1  write burst in progress.
REQ-010 bd_we  in  1, bd_addr  in  ADDR_BITS, bd_wdata  in  64  bench backdoor write; bd_rdata  out  64  registered backdoor read of bd_addr, 1-cycle latency.
REQ-011 err_oob  out  1  one-cycle pulse per out-of-window beat.

Function
REQ-012 SHALL implement FSM IDLE, RD_WAIT, RD_STREAM, WR_BURST; exactly one transaction active at a time.
REQ-013 IDLE: rd_req high -> rd_ack pulse next cycle, latch rd_addr/rd_burstcnt, go RD_WAIT; else wr_req high -> first-beat accept per REQ-017; read wins when both high.
REQ-014 SHALL ignore rd_req and wr_req in the cycle immediately after any rd_ack or final wr_ack (requestor drop delay).
REQ-015 Read beats SHALL start exactly RD_LATENCY cycles after rd_ack, one per cycle, contiguous, ascending addresses, rd_data_valid high only on beats; return to IDLE the cycle after last beat.
REQ-016 burstcnt 0 SHALL be treated as 1, on both read and write.
REQ-017 Write: each beat accepted with one-cycle wr_ack when wr_req high; first beat latches wr_addr/wr_burstcnt; beat k written at latched address + k; wr_busy high from cycle after first ack until cycle after last ack; non-final beats wait in WR_BURST with no timeout.
REQ-018 Byte lane i written only when wr_be[i]=1; be=0 beat still acked, RAM unchanged.
REQ-019 Beat address A in window iff BASE_QADDR <= A < BASE_QADDR + 2^ADDR_BITS, 29-bit unsigned compare; RAM index = A - BASE_QADDR truncated to ADDR_BITS.
REQ-020 Out-of-window read beat SHALL return 64'd0 with normal timing and pulse err_oob; out-of-window write beat SHALL be acked, dropped, pulse err_oob.
REQ-021 Burst crossing window end SHALL serve in-window beats normally and treat remainder per REQ-020; no address wrap.
REQ-022 Backdoor write SHALL take effect on same edge; backdoor and write-beat to same index same cycle -> protocol write wins.
REQ-023 Read beat at address written by a prior acked beat SHALL return new data (no stale read after wr_ack).
REQ-024 rd_data SHALL hold last beat value when rd_data_valid low.

Reset
REQ-025 On reset: FSM IDLE, rd_ack=0, rd_data_valid=0, rd_data=0, wr_ack=0, wr_busy=0, err_oob=0, bd_rdata=0; RAM contents unchanged.
REQ-026 Reset mid-burst SHALL abort immediately: no further rd_data_valid or wr_ack; next request after reset served normally.

Verification
REQ-027 Backdoor index 0 = 64'h00000001_06090000; rd_req addr 29'h06080000 burst 1 -> rd_ack, 2 cycles later one valid beat 64'h00000001_06090000.
REQ-028 Index 0x10/0x11 preloaded; read addr 29'h06080010 burst 2 -> two contiguous valid beats in order, FSM IDLE afterwards.
REQ-029 Index 1 = all ones; write addr 29'h06080001 data 0, be 8'h0F -> one wr_ack, wr_busy low after; backdoor reads 64'hFFFFFFFF_00000000.
REQ-030 Read addr 29'h06000000 burst 1 -> rd_ack, one beat 64'd0, one err_oob pulse; write burst 4 at 29'h06080FFE -> 4 wr_acks, 2 RAM updates, 2 err_oob pulses.
REQ-031 rd_req and wr_req high together in IDLE -> read served first; requestor holding rd_req one cycle past rd_ack produces no second rd_ack.
REQ-032 Reset asserted after 2nd of 4 read beats -> no further rd_data_valid, all outputs 0; new read after reset returns correct data.
